bp_wb64_to_wb32: RTL and testbench

Wishbone width downconverter that sits directly downstream of the BlackParrot 64-bit Wishbone bridge and in front of the 32-bit LiteX system bus. Each 64-bit classic-cycle access from the bridge becomes one or two 32-bit single accesses, low word first. The read halves are reassembled and returned with one ack pulse. A watchdog aborts master accesses that never terminate.

---
 rtl/bp2wb_pkg.sv | 24 ++
 rtl/bp2wb_watchdog.sv | 39 +++
 rtl/bp_wb64_to_wb32.sv | 142 ++++++++++++++
 tb/tb_bp_wb64_to_wb32.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp2wb_pkg.sv
// Shared definitions for the 64-to-32 bit Wishbone downconverter.
//   state_e   : converter FSM states (idle, low beat, high beat, response)
//   ERR_FILL  : read data returned for a beat that erred or timed out
//   CTI/BTE   : constant classic-cycle tags driven on the 32-bit bus
//   eff_sel() : maps the bridge's all-zero select to "all bytes"
package bp2wb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      RESP = 2'd3
   } state_e;

   localparam logic [31:0] ERR_FILL    = 32'hFFFF_FFFF;
   localparam logic [2:0]  CTI_CLASSIC = 3'b000;
   localparam logic [1:0]  BTE_LINEAR  = 2'b00;

   // The BlackParrot bridge ties sel low, which means a full dword access.
   function automatic logic [7:0] eff_sel(input logic [7:0] sel);
      return (sel == 8'h00) ? 8'hFF : sel;
   endfunction

endpackage

// File: rtl/bp2wb_watchdog.sv
// Clearable beat watchdog.
//   clk_i     : clock
//   reset_ni  : asynchronous active-low reset
//   clr_i     : return the count to zero (has priority over en_i)
//   en_i      : count while a master beat is outstanding
//   expire_o  : high in the cycle the count reaches timeout_p-1
// With timeout_p == 0 the watchdog is disabled and expire_o is tied low.
module bp2wb_watchdog #(
   parameter int timeout_p = 1024
) (
   input  logic clk_i,
   input  logic reset_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int CntW = (timeout_p < 1) ? 1 : $clog2(timeout_p + 1);

   generate
      if (timeout_p == 0) begin : g_off
         assign expire_o = 1'b0;
      end else begin : g_on
         localparam logic [CntW-1:0] Last = CntW'(timeout_p - 1);
         logic [CntW-1:0] cnt_q;

         always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni)   cnt_q <= '0;
            else if (clr_i)  cnt_q <= '0;
            else if (en_i)   cnt_q <= cnt_q + 1'b1;
         end

         // Deliberately independent of clr_i: the top derives clr_i from
         // expire_o, so gating here would close a combinational loop.
         assign expire_o = en_i && (cnt_q == Last);
      end
   endgenerate

endmodule

// File: rtl/bp_wb64_to_wb32.sv
// Wishbone 64-bit to 32-bit downconverter placed between the BlackParrot
// Wishbone bridge and the 32-bit LiteX bus. Each 64-bit classic access is
// split into up to two 32-bit single accesses, low word first; read halves
// are reassembled and returned with a single ack pulse.
//   s_* : 64-bit slave port (dword address, 8 byte selects, 0 = all bytes)
//   m_* : 32-bit master port (word address, classic cycles only)
//   s_err_o is raised with s_ack_o when any beat erred or was aborted by
//   the watchdog (timeout_p cycles per beat, 0 disables it).
module bp_wb64_to_wb32
   import bp2wb_pkg::*;
#(
   parameter int paddr_width_p = 40,
   parameter int timeout_p     = 1024
) (
   input  logic                     clk_i,
   input  logic                     reset_ni,
   input  logic [paddr_width_p-4:0] s_adr_i,
   input  logic [63:0]              s_dat_i,
   output logic [63:0]              s_dat_o,
   input  logic [7:0]               s_sel_i,
   input  logic                     s_we_i,
   input  logic                     s_stb_i,
   input  logic                     s_cyc_i,
   output logic                     s_ack_o,
   output logic                     s_err_o,
   output logic [paddr_width_p-3:0] m_adr_o,
   output logic [31:0]              m_dat_o,
   input  logic [31:0]              m_dat_i,
   output logic [3:0]               m_sel_o,
   output logic                     m_we_o,
   output logic                     m_stb_o,
   output logic                     m_cyc_o,
   output logic [2:0]               m_cti_o,
   output logic [1:0]               m_bte_o,
   input  logic                     m_ack_i,
   input  logic                     m_err_i
);

   state_e                   state_q;
   logic [paddr_width_p-4:0] adr_q;
   logic [63:0]              dat_q;
   logic [7:0]               sel_q;
   logic                     we_q;
   logic [63:0]              rdata_q;
   logic                     err_q;

   logic [7:0] sel_in_eff;
   logic       accept;
   logic       beat_act;
   logic       term;
   logic       fail;
   logic       wd_expire;
   logic       wd_clr;

   assign sel_in_eff = eff_sel(s_sel_i);
   assign accept     = (state_q == IDLE) && s_stb_i && s_cyc_i;
   assign beat_act   = (state_q == LO) || (state_q == HI);
   // A watchdog expiry is treated exactly like m_err_i; err beats ack.
   assign fail       = beat_act && (m_err_i || wd_expire);
   assign term       = beat_act && (m_ack_i || m_err_i || wd_expire);
   // Restart the count on every beat entry, including LO -> HI.
   assign wd_clr     = !beat_act || ((state_q == LO) && term);

   bp2wb_watchdog #(
      .timeout_p(timeout_p)
   ) u_watchdog (
      .clk_i   (clk_i),
      .reset_ni(reset_ni),
      .clr_i   (wd_clr),
      .en_i    (beat_act),
      .expire_o(wd_expire)
   );

   // Request fields only matter while a beat is active, so they carry no reset.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         adr_q <= s_adr_i;
         dat_q <= s_dat_i;
         sel_q <= sel_in_eff;
         we_q  <= s_we_i;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= IDLE;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  rdata_q <= '0;
                  err_q   <= 1'b0;
                  state_q <= (sel_in_eff[3:0] != 4'h0) ? LO : HI;
               end
            end
            LO: begin
               if (fail) begin
                  rdata_q[31:0] <= ERR_FILL;
                  err_q         <= 1'b1;
               end else if (m_ack_i) begin
                  rdata_q[31:0] <= m_dat_i;
               end
               // A failed low beat still lets the high beat run.
               if (term) state_q <= (sel_q[7:4] != 4'h0) ? HI : RESP;
            end
            HI: begin
               if (fail) begin
                  rdata_q[63:32] <= ERR_FILL;
                  err_q          <= 1'b1;
               end else if (m_ack_i) begin
                  rdata_q[63:32] <= m_dat_i;
               end
               if (term) state_q <= RESP;
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Master side is decoded from registered state only, so no s_* input
   // reaches an m_* output combinationally, and async reset clears it at once.
   assign m_stb_o = beat_act;
   assign m_cyc_o = beat_act;
   assign m_we_o  = beat_act && we_q;
   assign m_adr_o = beat_act ? {adr_q, (state_q == HI)} : '0;
   assign m_dat_o = (state_q == HI) ? dat_q[63:32] :
                    (state_q == LO) ? dat_q[31:0]  : 32'h0;
   assign m_sel_o = (state_q == HI) ? sel_q[7:4] :
                    (state_q == LO) ? sel_q[3:0] : 4'h0;
   assign m_cti_o = CTI_CLASSIC;
   assign m_bte_o = BTE_LINEAR;

   // RESP lasts one cycle and is always followed by IDLE, so acks never
   // land on consecutive cycles.
   assign s_ack_o = (state_q == RESP);
   assign s_err_o = (state_q == RESP) && err_q;
   assign s_dat_o = rdata_q;

endmodule

// File: tb/tb_bp_wb64_to_wb32.sv
module tb_bp_wb64_to_wb32;

   localparam int PADDR = 40;
   localparam int TMO   = 16;

   logic              clk_i = 1'b0;
   logic              reset_ni = 1'b0;
   logic [PADDR-4:0]  s_adr_i = '0;
   logic [63:0]       s_dat_i = '0;
   logic [63:0]       s_dat_o;
   logic [7:0]        s_sel_i = '0;
   logic              s_we_i = 1'b0, s_stb_i = 1'b0, s_cyc_i = 1'b0;
   logic              s_ack_o, s_err_o;
   logic [PADDR-3:0]  m_adr_o;
   logic [31:0]       m_dat_o;
   logic [31:0]       m_dat_i = '0;
   logic [3:0]        m_sel_o;
   logic              m_we_o, m_stb_o, m_cyc_o;
   logic [2:0]        m_cti_o;
   logic [1:0]        m_bte_o;
   logic              m_ack_i = 1'b0, m_err_i = 1'b0;

   bp_wb64_to_wb32 #(.paddr_width_p(PADDR), .timeout_p(TMO)) dut (
      .clk_i(clk_i), .reset_ni(reset_ni),
      .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_sel_i(s_sel_i),
      .s_we_i(s_we_i), .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i),
      .s_ack_o(s_ack_o), .s_err_o(s_err_o),
      .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_sel_o(m_sel_o),
      .m_we_o(m_we_o), .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o),
      .m_cti_o(m_cti_o), .m_bte_o(m_bte_o),
      .m_ack_i(m_ack_i), .m_err_i(m_err_i)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   // Beat response codes: 0 ack, 1 err, 2 ack+err together, 3 never respond.
   typedef struct {
      logic             we;
      logic [PADDR-4:0] adr;
      logic [63:0]      dat;
      logic [7:0]       sel;
      logic [31:0]      rd_lo, rd_hi;
      logic [1:0]       code_lo, code_hi;
      int               waits;
      logic [63:0]      exp_sdat;
      logic             exp_err;
      int               exp_lat;
   } txn_t;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " s_ack"}, s_ack_o, 0);
      chk({tag, " s_err"}, s_err_o, 0);
      chk({tag, " s_dat"}, s_dat_o, 0);
      chk({tag, " m_adr"}, m_adr_o, 0);
      chk({tag, " m_dat"}, m_dat_o, 0);
      chk({tag, " m_sel"}, m_sel_o, 0);
      chk({tag, " m_we"},  m_we_o, 0);
      chk({tag, " m_stb"}, m_stb_o, 0);
      chk({tag, " m_cyc"}, m_cyc_o, 0);
      chk({tag, " m_cti"}, m_cti_o, 0);
      chk({tag, " m_bte"}, m_bte_o, 0);
   endtask

   function automatic txn_t mk(input logic we, input logic [PADDR-4:0] adr, input logic [63:0] dat,
                               input logic [7:0] sel, input logic [31:0] rd_lo, input logic [31:0] rd_hi,
                               input logic [1:0] clo, input logic [1:0] chi, input int waits,
                               input logic [63:0] exp_sdat, input logic exp_err, input int exp_lat);
      txn_t t;
      t.we = we; t.adr = adr; t.dat = dat; t.sel = sel; t.rd_lo = rd_lo; t.rd_hi = rd_hi;
      t.code_lo = clo; t.code_hi = chi; t.waits = waits;
      t.exp_sdat = exp_sdat; t.exp_err = exp_err; t.exp_lat = exp_lat;
      return t;
   endfunction

   // Reference: which 32-bit halves are touched, what each returns, and how
   // many cycles each beat occupies (response after waits, or a full timeout).
   function automatic txn_t model(input txn_t t);
      txn_t       r;
      logic [7:0] se;
      logic [1:0] code;
      r  = t;
      se = (t.sel == 8'h00) ? 8'hFF : t.sel;
      r.exp_sdat = '0;
      r.exp_err  = 1'b0;
      r.exp_lat  = 1;
      for (int h = 0; h < 2; h++) begin
         if (se[h*4 +: 4] != 4'h0) begin
            code = (h == 1) ? t.code_hi : t.code_lo;
            if (code == 2'd0) r.exp_sdat[h*32 +: 32] = (h == 1) ? t.rd_hi : t.rd_lo;
            else begin
               r.exp_sdat[h*32 +: 32] = 32'hFFFF_FFFF;
               r.exp_err = 1'b1;
            end
            r.exp_lat += (code == 2'd3) ? TMO : t.waits + 1;
         end
      end
      return r;
   endfunction

   // Called at a negedge; returns at the negedge of the idle cycle after the ack.
   task automatic run(input txn_t t, input string tag);
      logic [7:0]       se;
      int               halves[$];
      int               cyc, nb, wcnt, h;
      logic             done, prev_stb;
      logic [PADDR-3:0] prev_adr;
      logic [1:0]       code;
      se = (t.sel == 8'h00) ? 8'hFF : t.sel;
      for (int k = 0; k < 2; k++) if (se[k*4 +: 4] != 4'h0) halves.push_back(k);
      s_adr_i = t.adr; s_dat_i = t.dat; s_sel_i = t.sel; s_we_i = t.we;
      s_stb_i = 1'b1;  s_cyc_i = 1'b1;
      cyc = 0; nb = 0; wcnt = 0; done = 1'b0; prev_stb = 1'b0; prev_adr = '0;
      while (!done && cyc < 100) begin
         @(posedge clk_i);
         @(negedge clk_i);
         cyc++;
         m_ack_i = 1'b0;
         m_err_i = 1'b0;
         if (s_ack_o) begin
            done = 1'b1;
            chk({tag, " latency"}, cyc, t.exp_lat);
            chk({tag, " s_dat"},   s_dat_o, t.exp_sdat);
            chk({tag, " s_err"},   s_err_o, t.exp_err);
            chk({tag, " beats"},   nb, halves.size());
         end else if (m_stb_o) begin
            if (!prev_stb || m_adr_o != prev_adr) begin
               if (nb < halves.size()) begin
                  h = halves[nb];
                  chk({tag, " m_adr"}, m_adr_o, {t.adr, 1'(h)});
                  chk({tag, " m_sel"}, m_sel_o, se[h*4 +: 4]);
                  chk({tag, " m_we"},  m_we_o, t.we);
                  chk({tag, " m_cyc"}, m_cyc_o, 1);
                  if (t.we) chk({tag, " m_dat"}, m_dat_o, t.dat[h*32 +: 32]);
               end
               nb++;
               wcnt = 0;
            end else begin
               wcnt++;
            end
            code = m_adr_o[0] ? t.code_hi : t.code_lo;
            if (code != 2'd3 && wcnt == t.waits) begin
               m_dat_i = m_adr_o[0] ? t.rd_hi : t.rd_lo;
               m_ack_i = (code != 2'd1);
               m_err_i = (code != 2'd0);
            end
         end
         prev_stb = m_stb_o;
         prev_adr = m_adr_o;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s no s_ack_o: waited %0d cycles, required by cycle %0d", tag, cyc, t.exp_lat);
      end
      // Stay high through the response cycle like the bridge, then drop.
      @(posedge clk_i);
      #1;
      s_stb_i = 1'b0; s_cyc_i = 1'b0; m_ack_i = 1'b0; m_err_i = 1'b0;
      @(negedge clk_i);
      chk({tag, " ack one cycle"}, s_ack_o, 0);
      chk({tag, " no re-accept"}, m_stb_o, 0);
   endtask

   txn_t tbl[8];
   txn_t t;
   int   r;

   initial begin
      tbl[0] = mk(0, 37'h0_0800_0000, 64'h0, 8'h00, 32'h1111_1111, 32'h2222_2222, 0, 0, 0,
                  64'h2222_2222_1111_1111, 0, 3);
      tbl[1] = mk(1, 37'h0_0000_0040, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 32'h0, 32'h0, 0, 0, 0,
                  64'h0, 0, 2);
      tbl[2] = mk(1, 37'h0_0000_0041, 64'hAAAA_BBBB_CCCC_DDDD, 8'hF0, 32'h0, 32'h0, 0, 0, 0,
                  64'h0, 0, 2);
      tbl[3] = mk(0, 37'h0_1234_5678, 64'h0, 8'h00, 32'h3333_3333, 32'h4444_4444, 0, 1, 0,
                  64'hFFFF_FFFF_3333_3333, 1, 3);
      tbl[4] = mk(0, 37'h0_0000_1000, 64'h0, 8'h00, 32'h5555_5555, 32'h6666_6666, 3, 0, 0,
                  64'h6666_6666_FFFF_FFFF, 1, 18);
      tbl[5] = mk(0, 37'h1_0000_0002, 64'h0, 8'h00, 32'h7777_7777, 32'h8888_8888, 2, 0, 0,
                  64'h8888_8888_FFFF_FFFF, 1, 3);
      tbl[6] = mk(0, 37'h0_00AB_CDEF, 64'h0, 8'h3C, 32'h9999_9999, 32'hAAAA_AAAA, 0, 0, 2,
                  64'hAAAA_AAAA_9999_9999, 0, 7);
      tbl[7] = mk(0, 37'h0_0000_0007, 64'h0, 8'h00, 32'h1, 32'h2, 3, 3, 0,
                  64'hFFFF_FFFF_FFFF_FFFF, 1, 33);

      repeat (3) @(negedge clk_i);
      chk_idle("reset");
      reset_ni = 1'b1;
      @(negedge clk_i);
      chk_idle("after reset");

      for (int i = 0; i < 8; i++) run(tbl[i], $sformatf("vec%0d", i));

      // Bridge-style back-to-back requests, then the bus must stay quiet.
      run(model(mk(0, 37'h0_0000_0100, 64'h0, 8'h00, 32'hBEEF_0001, 32'hBEEF_0002, 0, 0, 0, 0, 0, 0)), "b2b_a");
      run(model(mk(1, 37'h0_0000_0200, 64'h0123_4567_89AB_CDEF, 8'h00, 32'h0, 32'h0, 0, 0, 1, 0, 0, 0)), "b2b_b");
      repeat (3) begin
         @(negedge clk_i);
         chk("b2b quiet stb", m_stb_o, 0);
         chk("b2b quiet ack", s_ack_o, 0);
      end

      for (int i = 0; i < 40; i++) begin
         t.we    = 1'($urandom_range(0, 1));
         t.adr   = 37'({$urandom(), $urandom()});
         t.dat   = {$urandom(), $urandom()};
         t.sel   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
         t.rd_lo = $urandom();
         t.rd_hi = $urandom();
         r = $urandom_range(0, 9);
         t.code_lo = (r < 7) ? 2'd0 : 2'(r - 6);
         r = $urandom_range(0, 9);
         t.code_hi = (r < 7) ? 2'd0 : 2'(r - 6);
         t.waits = $urandom_range(0, 3);
         run(model(t), $sformatf("rnd%0d", i));
      end

      // Asynchronous reset while in the high beat with an ack pending.
      s_adr_i = 37'h0_0ABC_DEF0; s_dat_i = '0; s_sel_i = 8'h00; s_we_i = 1'b0;
      s_stb_i = 1'b1; s_cyc_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_mid low beat stb", m_stb_o, 1);
      m_ack_i = 1'b1;
      m_dat_i = 32'h1234_5678;
      @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_mid high beat adr", m_adr_o, {37'h0_0ABC_DEF0, 1'b1});
      m_dat_i = 32'h8765_4321;
      #1 reset_ni = 1'b0;
      #1 chk_idle("rst_mid async");
      s_stb_i = 1'b0; s_cyc_i = 1'b0; m_ack_i = 1'b0;
      repeat (2) begin
         @(posedge clk_i);
         @(negedge clk_i);
         chk("rst_mid no ack", s_ack_o, 0);
      end
      reset_ni = 1'b1;
      @(negedge clk_i);
      chk_idle("rst_mid released");
      run(model(mk(0, 37'h0_0ABC_DEF0, 64'h0, 8'h00, 32'hCAFE_0001, 32'hCAFE_0002, 0, 0, 1, 0, 0, 0)), "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
